gemm_seq_ctrl: RTL
==================

Name: gemm_seq_ctrl

Overview:
- Sequencer directly downstream of the GEMM parameter-transfer stage.
- Consumes its start pulse and latched GEMM parameters. Produces the busy state code it uses to gate nice_req_ready, and the fin pulse that raises the multi-cycle response.
- Walks the triple loop i (lhs row), j (rhs row / output channel), k (inner dimension). Emits a per-element operand-address stream to the MAC datapath and a per-output write-address stream to the requant/store stage.

Parameters:
- DIM_W, 16, width of the i/j/k counters; dimension inputs are truncated to their low DIM_W bits.
- ADDR_W, 32, byte-address width; all address arithmetic wraps modulo 2^ADDR_W.

Ports:
- nice_clk  in  1  clock
- nice_rst  in  1  reset, asynchronous, active-high
- start  in  1  single-cycle launch request; honoured only in IDLE
- lhs_rows  in  32  M
- rhs_rows  in  32  N (output channels)
- rhs_cols  in  32  K (inner dimension, int8 elements)
- lhs_addr, rhs_addr, dst_addr  in  32 each  base byte addresses
- state  out  2  00 IDLE, 01 FETCH, 10 WRITE, 11 DONE
- fin  out  1  one-cycle pulse at completion
- op_valid  out  1  operand request valid
- op_ready  in  1  MAC accepts operand request
- op_lhs_addr, op_rhs_addr  out  ADDR_W each  element addresses
- op_first  out  1  k==0; MAC clears accumulator
- op_last  out  1  k==K-1; MAC closes accumulation
- wr_valid  out  1  output write request valid
- wr_ready  in  1  store stage accepts
- wr_dst_addr  out  ADDR_W  dst_addr + i*N + j
- wr_chan  out  DIM_W  j; used to index bias/multiplier/shift tables

Behaviour:
- Reset (asynchronous, active-high): state=00, fin=0, op_valid=0, wr_valid=0, all address/counter registers 0. Reset mid-run abandons the run; no fin is issued.
- IDLE, start=1:
  - Latch M, N, K, the three bases, and row pointers lhs_row=lhs_addr, rhs_row=rhs_addr, dst_ptr=dst_addr. Clear i, j, k.
  - If M, N or K (truncated) equals 0: go to DONE with no op/wr traffic.
  - Otherwise go to FETCH.
  - start outside IDLE is ignored.
- Registered outputs: op_valid and state both change one cycle after start.
- FETCH:
  - Drive op_valid=1, op_lhs_addr=lhs_row+k, op_rhs_addr=rhs_row+k, op_first=(k==0), op_last=(k==K-1).
  - On op_valid&op_ready: if k<K-1, k++. Otherwise k=0, op_valid drops, go to WRITE.
  - Outputs must be held stable while op_valid&!op_ready.
  - Throughput is one operand per cycle under continuous op_ready.
- WRITE:
  - wr_valid=1, wr_dst_addr=dst_ptr, wr_chan=j. Hold stable until wr_ready.
  - On handshake, dst_ptr++, then:
    - j<N-1: j++, rhs_row+=K, back to FETCH.
    - else if i<M-1: j=0, i++, rhs_row=rhs_addr, lhs_row+=K, back to FETCH.
    - else: go to DONE.
- Address updates are incremental adds only; no multipliers.
- DONE: fin=1 for exactly one cycle, then IDLE the next cycle. state reads 11 during that cycle.
- The upstream stage sees ready only when state==00.
- Outputs emitted in row-major order: i outer, j middle, k inner.
- The output count per run is exactly M*N; the operand count is exactly M*N*K.

Decomposition:
- Shared package gemm_pkg holds:
  - state encoding constants ST_IDLE=2'b00, ST_FETCH=2'b01, ST_WRITE=2'b10, ST_DONE=2'b11;
  - DIM_W and ADDR_W defaults.
- One natural sub-module, gemm_loop_cnt: a wrap counter with inc/limit inputs and last/wrap outputs. It is instantiated three times for i, j and k.

Test Plan:
- M=2, N=3, K=4, lhs=0x1000, rhs=0x2000, dst=0x3000, ready tied high:
  - 24 ops; first op (0x1000, 0x2000, first=1).
  - 4th op (0x1003, 0x2003, last=1).
  - 6 writes at 0x3000..0x3005 with wr_chan 0,1,2,0,1,2.
  - fin exactly once; state returns to 00.
- Same run with op_ready toggling 1-0-1 and wr_ready delayed 3 cycles:
  - addresses are held stable while stalled;
  - counts are unchanged (24/6);
  - no op is duplicated or dropped.
- K=0 (M=2, N=2):
  - start -> DONE next cycle, fin pulse;
  - zero op_valid and zero wr_valid cycles.
- Start pulse during FETCH: ignored; the running job completes unaltered with a single fin.
- Reset asserted mid-FETCH:
  - op_valid, wr_valid and fin go to 0 immediately;
  - state=00;
  - a new start afterwards with M=N=K=1 yields 1 op, 1 write, 1 fin.
- Base address wrap: lhs=0xFFFFFFFE, K=4 → op_lhs_addr sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001.

Source files
------------

// File: rtl/gemm_pkg.sv
// Shared encodings and default widths for the GEMM sequencer.
package gemm_pkg;
   localparam int DIM_W_DEF  = 16;
   localparam int ADDR_W_DEF = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_FETCH = 2'b01,
      ST_WRITE = 2'b10,
      ST_DONE  = 2'b11
   } gemm_state_e;
endpackage

// File: rtl/gemm_loop_cnt.sv
// Wrap counter for one GEMM loop index: counts 0..limit-1 on inc, wraps to 0.
module gemm_loop_cnt #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   input  logic [W-1:0] limit,
   output logic [W-1:0] cnt,
   output logic         last,
   output logic         wrap
);
   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (inc)
         cnt_d = last ? '0 : cnt_q + W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign cnt  = cnt_q;
   assign last = (cnt_q == limit - W'(1));
   assign wrap = inc & last;
endmodule

// File: rtl/gemm_seq_ctrl.sv
// GEMM loop sequencer: walks i/j/k, streams operand addresses to the MAC
// and output addresses to the store stage using incremental adds only.
module gemm_seq_ctrl
   import gemm_pkg::*;
#(
   parameter int DIM_W  = DIM_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              nice_clk,
   input  logic              nice_rst,
   input  logic              start,
   input  logic [31:0]       lhs_rows,
   input  logic [31:0]       rhs_rows,
   input  logic [31:0]       rhs_cols,
   input  logic [ADDR_W-1:0] lhs_addr,
   input  logic [ADDR_W-1:0] rhs_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   output logic [1:0]        state,
   output logic              fin,
   output logic              op_valid,
   input  logic              op_ready,
   output logic [ADDR_W-1:0] op_lhs_addr,
   output logic [ADDR_W-1:0] op_rhs_addr,
   output logic              op_first,
   output logic              op_last,
   output logic              wr_valid,
   input  logic              wr_ready,
   output logic [ADDR_W-1:0] wr_dst_addr,
   output logic [DIM_W-1:0]  wr_chan
);
   gemm_state_e       state_q, state_d;
   logic [DIM_W-1:0]  m_q, m_d, n_q, n_d, k_q, k_d;
   logic [ADDR_W-1:0] rhs_base_q, rhs_base_d;
   logic [ADDR_W-1:0] lhs_row_q, lhs_row_d, rhs_row_q, rhs_row_d, dst_ptr_q, dst_ptr_d;
   logic              cnt_clr, i_inc, j_inc, k_inc;
   logic [DIM_W-1:0]  i_cnt, j_cnt, k_cnt;
   logic              i_last, j_last, k_last, i_wrap, j_wrap, k_wrap;
   logic [ADDR_W-1:0] k_ext;

   assign k_ext = ADDR_W'(k_q);

   gemm_loop_cnt #(.W(DIM_W)) u_i_cnt (.clk(nice_clk), .rst(nice_rst), .clr(cnt_clr), .inc(i_inc),
      .limit(m_q), .cnt(i_cnt), .last(i_last), .wrap(i_wrap));
   gemm_loop_cnt #(.W(DIM_W)) u_j_cnt (.clk(nice_clk), .rst(nice_rst), .clr(cnt_clr), .inc(j_inc),
      .limit(n_q), .cnt(j_cnt), .last(j_last), .wrap(j_wrap));
   gemm_loop_cnt #(.W(DIM_W)) u_k_cnt (.clk(nice_clk), .rst(nice_rst), .clr(cnt_clr), .inc(k_inc),
      .limit(k_q), .cnt(k_cnt), .last(k_last), .wrap(k_wrap));

   always_comb begin
      state_d    = state_q;
      m_d        = m_q;
      n_d        = n_q;
      k_d        = k_q;
      rhs_base_d = rhs_base_q;
      lhs_row_d  = lhs_row_q;
      rhs_row_d  = rhs_row_q;
      dst_ptr_d  = dst_ptr_q;
      cnt_clr    = 1'b0;
      i_inc      = 1'b0;
      j_inc      = 1'b0;
      k_inc      = 1'b0;
      case (state_q)
         ST_IDLE: if (start) begin
            m_d        = lhs_rows[DIM_W-1:0];
            n_d        = rhs_rows[DIM_W-1:0];
            k_d        = rhs_cols[DIM_W-1:0];
            rhs_base_d = rhs_addr;
            lhs_row_d  = lhs_addr;
            rhs_row_d  = rhs_addr;
            dst_ptr_d  = dst_addr;
            cnt_clr    = 1'b1;
            // An empty dimension produces no traffic but still completes with fin.
            state_d    = (m_d == '0 || n_d == '0 || k_d == '0) ? ST_DONE : ST_FETCH;
         end
         ST_FETCH: if (op_ready) begin
            k_inc = 1'b1;
            if (k_last) state_d = ST_WRITE;
         end
         ST_WRITE: if (wr_ready) begin
            dst_ptr_d = dst_ptr_q + ADDR_W'(1);
            j_inc     = 1'b1;
            if (!j_last) begin
               rhs_row_d = rhs_row_q + k_ext;
               state_d   = ST_FETCH;
            end else if (!i_last) begin
               i_inc     = 1'b1;
               rhs_row_d = rhs_base_q;
               lhs_row_d = lhs_row_q + k_ext;
               state_d   = ST_FETCH;
            end else begin
               state_d   = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge nice_clk or posedge nice_rst) begin
      if (nice_rst) begin
         state_q    <= ST_IDLE;
         m_q        <= '0;
         n_q        <= '0;
         k_q        <= '0;
         rhs_base_q <= '0;
         lhs_row_q  <= '0;
         rhs_row_q  <= '0;
         dst_ptr_q  <= '0;
      end else begin
         state_q    <= state_d;
         m_q        <= m_d;
         n_q        <= n_d;
         k_q        <= k_d;
         rhs_base_q <= rhs_base_d;
         lhs_row_q  <= lhs_row_d;
         rhs_row_q  <= rhs_row_d;
         dst_ptr_q  <= dst_ptr_d;
      end
   end

   assign state       = state_q;
   assign fin         = (state_q == ST_DONE);
   assign op_valid    = (state_q == ST_FETCH);
   assign op_lhs_addr = lhs_row_q + ADDR_W'(k_cnt);
   assign op_rhs_addr = rhs_row_q + ADDR_W'(k_cnt);
   assign op_first    = (k_cnt == '0);
   assign op_last     = k_last;
   assign wr_valid    = (state_q == ST_WRITE);
   assign wr_dst_addr = dst_ptr_q;
   assign wr_chan     = j_cnt;

   logic unused_bits;
   assign unused_bits = ^{lhs_rows[31:DIM_W], rhs_rows[31:DIM_W], rhs_cols[31:DIM_W],
                          i_cnt, i_wrap, j_wrap, k_wrap};
endmodule
